alu_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one 4-bit add/sub ALU and the zero-constant mux between two 4-bit registers (REG_A, REG_B) in the register-transfer datapath. It accepts single-cycle requests from the debounced load pulses of two channels, queues one command per channel, and drives ALU select, operand select, zero-mux select and register load enables through a fixed SETUP/WRITE sequence. It sits between the per-channel Load pulse generators and the shared REG/ALU/MUX datapath. Its per-channel completion counters feed the 7-segment display.

---
 rtl/alu_share_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Two-channel sequencer and round-robin arbiter sharing one add/sub ALU and the
// zero-constant mux between REG_A and REG_B through a SETUP/WRITE sequence.
module alu_share_ctrl #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             sub_a,
    input  logic             sub_b,
    input  logic             clr_a,
    input  logic             clr_b,
    output logic [1:0]       alu_s,
    output logic             opnd_sel,
    output logic             zero_sel,
    output logic             load_a,
    output logic             load_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             busy,
    output logic [CNT_W-1:0] ops_a,
    output logic [CNT_W-1:0] ops_b
);

    localparam int unsigned SET_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             pend_a;
    logic             pend_b;
    logic             cmd_clr_a;
    logic             cmd_sub_a;
    logic             cmd_clr_b;
    logic             cmd_sub_b;
    logic             rr;
    logic             act_b;
    logic             act_clr;
    logic             act_sub;
    logic [SET_W-1:0] set_cnt;

    logic             grant_c;
    logic             grant_b_c;
    logic             write_a_c;
    logic             write_b_c;

    assign write_a_c = (state == WRITE) && !act_b;
    assign write_b_c = (state == WRITE) &&  act_b;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decision
    always_comb begin
        state_nxt = state;
        grant_c   = 1'b0;
        grant_b_c = 1'b0;
        case (state)
            IDLE: begin
                if (pend_a || pend_b) begin
                    grant_c   = 1'b1;
                    grant_b_c = pend_b && (!pend_a || rr);
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (set_cnt == '0) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the registered state and active command
    always_comb begin
        alu_s    = 2'b00;
        opnd_sel = 1'b0;
        zero_sel = 1'b0;
        load_a   = 1'b0;
        load_b   = 1'b0;
        ack_a    = 1'b0;
        ack_b    = 1'b0;
        busy     = 1'b0;
        if (state == SETUP || state == WRITE) begin
            alu_s    = {1'b0, act_sub};
            opnd_sel = act_b;
            zero_sel = act_clr;
            busy     = 1'b1;
        end
        if (state == WRITE) begin
            load_a = !act_b;
            load_b =  act_b;
            ack_a  = !act_b;
            ack_b  =  act_b;
        end
    end

    // Per-channel pending flag and command; a request during its own WRITE re-arms it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_a    <= 1'b0;
            cmd_clr_a <= 1'b0;
            cmd_sub_a <= 1'b0;
            pend_b    <= 1'b0;
            cmd_clr_b <= 1'b0;
            cmd_sub_b <= 1'b0;
        end else begin
            if (req_a && (!pend_a || write_a_c)) begin
                pend_a    <= 1'b1;
                cmd_clr_a <= clr_a;
                cmd_sub_a <= sub_a;
            end else if (write_a_c) begin
                pend_a <= 1'b0;
            end
            if (req_b && (!pend_b || write_b_c)) begin
                pend_b    <= 1'b1;
                cmd_clr_b <= clr_b;
                cmd_sub_b <= sub_b;
            end else if (write_b_c) begin
                pend_b <= 1'b0;
            end
        end
    end

    // Active command, round-robin pointer and settle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr      <= 1'b0;
            act_b   <= 1'b0;
            act_clr <= 1'b0;
            act_sub <= 1'b0;
            set_cnt <= '0;
        end else begin
            if (grant_c) begin
                act_b   <= grant_b_c;
                act_clr <= grant_b_c ? cmd_clr_b : cmd_clr_a;
                act_sub <= grant_b_c ? cmd_sub_b : cmd_sub_a;
                rr      <= !grant_b_c;
                set_cnt <= SET_W'(SETUP_CYCLES - 1);
            end else if (state == SETUP && set_cnt != '0) begin
                set_cnt <= set_cnt - SET_W'(1);
            end
        end
    end

    // Completion counters advance on the edge that ends WRITE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ops_a <= '0;
            ops_b <= '0;
        end else begin
            if (write_a_c) begin
                ops_a <= ops_a + CNT_W'(1);
            end
            if (write_b_c) begin
                ops_b <= ops_b + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: vector table plus scoreboard of
// expected WRITE cycles, and hand sequences for latency, alternation, drop, wrap, reset.
module tb_alu_share_ctrl;

    logic       clk;
    logic       rst;
    logic       req_a, req_b, sub_a, sub_b, clr_a, clr_b;
    logic [1:0] alu_s;
    logic       opnd_sel, zero_sel, load_a, load_b, ack_a, ack_b, busy;
    logic [7:0] ops_a, ops_b;

    alu_share_ctrl #(.SETUP_CYCLES(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .sub_a(sub_a), .sub_b(sub_b),
        .clr_a(clr_a), .clr_b(clr_b),
        .alu_s(alu_s), .opnd_sel(opnd_sel), .zero_sel(zero_sel),
        .load_a(load_a), .load_b(load_b), .ack_a(ack_a), .ack_b(ack_b),
        .busy(busy), .ops_a(ops_a), .ops_b(ops_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic sub;
        logic clr;
    } exp_t;

    typedef struct {
        logic ra, sa, ca;
        logic rb, sb, cb;
        logic first_b;
    } vec_t;

    exp_t       q[$];
    vec_t       vt[8];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_ops_a, m_ops_b;
    logic       s_busy, s_load_a, s_ack_a, s_ack_b;
    int         n_load_a = 0;
    int         n_ack_b  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic push(input logic b, input logic sub, input logic clr);
        exp_t e;
        e.b = b; e.sub = sub; e.clr = clr;
        q.push_back(e);
    endtask

    // Sample and score the DUT outputs (called at the falling edge)
    task automatic mon();
        exp_t e;
        s_busy   = busy;
        s_load_a = load_a;
        s_ack_a  = ack_a;
        s_ack_b  = ack_b;
        if (load_a) n_load_a++;
        if (ack_b)  n_ack_b++;
        if (load_a || load_b) begin
            if (q.size() == 0) begin
                chk("unexpected_load", {30'd0, load_a, load_b}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("write_ctl", {23'd0, load_a, load_b, ack_a, ack_b, alu_s, opnd_sel, zero_sel, busy},
                    {23'd0, !e.b, e.b, !e.b, e.b, 1'b0, e.sub, e.b, e.clr, 1'b1});
                if (e.b) begin
                    chk("ops_b_pre", 32'(ops_b), 32'(m_ops_b));
                    m_ops_b = m_ops_b + 8'd1;
                end else begin
                    chk("ops_a_pre", 32'(ops_a), 32'(m_ops_a));
                    m_ops_a = m_ops_a + 8'd1;
                end
            end
        end else if (busy) begin
            if (q.size() == 0) begin
                chk("unexpected_busy", {31'd0, busy}, 32'd0);
            end else begin
                chk("setup_sel", {26'd0, alu_s, opnd_sel, zero_sel, ack_a, ack_b},
                    {26'd0, 1'b0, q[0].sub, q[0].b, q[0].clr, 2'b00});
            end
        end else begin
            chk("idle_out", {26'd0, alu_s, opnd_sel, zero_sel, ack_a, ack_b}, 32'd0);
        end
    endtask

    // One clock: sample at the falling edge, return just after the rising edge
    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while ((q.size() != 0 || s_busy) && n < budget);
        chk("drain", {30'd0, q.size() != 0, s_busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_a = 0; req_b = 0; sub_a = 0; sub_b = 0; clr_a = 0; clr_b = 0;
        q.delete();
        m_ops_a = 8'd0;
        m_ops_b = 8'd0;
        #1;
        chk("reset_out", {7'd0, alu_s, opnd_sel, zero_sel, load_a, load_b, ack_a, ack_b, busy, ops_a, ops_b}, 32'd0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        int k;
        int n;
        int n_rep;
        int base;

        // ra sa ca rb sb cb first_b; rr bookkeeping is tracked by hand from reset
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        req_a = 0; req_b = 0; sub_a = 0; sub_b = 0; clr_a = 0; clr_b = 0;
        #1;
        do_reset();

        // Single A increment: load 3 edges after the request edge
        req_a = 1'b1;
        push(1'b0, 1'b0, 1'b0);
        k = 0;
        s_load_a = 1'b0;
        while (k < 10 && !s_load_a) begin
            cyc();
            k++;
            if (k == 1) req_a = 1'b0;
            if (k == 2) chk("busy_pre_grant", {31'd0, s_busy}, 32'd0);
            if (k == 3) chk("busy_setup", {31'd0, s_busy}, 32'd1);
        end
        chk("latency_edges", 32'(k - 1), 32'd3);
        cyc();
        chk("busy_after_write", {31'd0, s_busy}, 32'd0);
        chk("ops_a_one", 32'(ops_a), 32'd1);
        chk("ops_b_zero", 32'(ops_b), 32'd0);

        // Both channels re-requesting in their own WRITE cycle: strict alternation
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        push(1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
        cyc();
        req_a = 1'b0; req_b = 1'b0;
        n_rep = 0;
        n = 0;
        while (n < 200 && !(n_rep == 6 && q.size() == 0 && !s_busy)) begin
            @(negedge clk);
            mon();
            if (s_ack_a && n_rep < 6) begin
                req_a = 1'b1; push(1'b0, 1'b0, 1'b0); n_rep++;
            end else if (s_ack_b && n_rep < 6) begin
                req_b = 1'b1; push(1'b1, 1'b0, 1'b0); n_rep++;
            end
            @(posedge clk);
            #1;
            req_a = 1'b0; req_b = 1'b0;
            n++;
        end
        chk("alt_drain", {30'd0, q.size() != 0, s_busy}, 32'd0);
        chk("alt_ops_a", 32'(ops_a), 32'd4);
        chk("alt_ops_b", 32'(ops_b), 32'd4);

        // Vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_a = vt[i].ra; sub_a = vt[i].sa; clr_a = vt[i].ca;
            req_b = vt[i].rb; sub_b = vt[i].sb; clr_b = vt[i].cb;
            if (vt[i].ra && vt[i].rb) begin
                if (vt[i].first_b) begin
                    push(1'b1, vt[i].sb, vt[i].cb);
                    push(1'b0, vt[i].sa, vt[i].ca);
                end else begin
                    push(1'b0, vt[i].sa, vt[i].ca);
                    push(1'b1, vt[i].sb, vt[i].cb);
                end
            end else if (vt[i].ra) begin
                push(1'b0, vt[i].sa, vt[i].ca);
            end else begin
                push(1'b1, vt[i].sb, vt[i].cb);
            end
            cyc();
            req_a = 1'b0; req_b = 1'b0;
            wait_idle(40);
        end
        chk("table_ops_a", 32'(ops_a), 32'd6);
        chk("table_ops_b", 32'(ops_b), 32'd5);

        // Clear on B, then a second request while pending is dropped
        base = n_ack_b;
        req_b = 1'b1; clr_b = 1'b1; sub_b = 1'b1;
        push(1'b1, 1'b1, 1'b1);
        cyc();
        clr_b = 1'b0; sub_b = 1'b0;
        cyc();
        req_b = 1'b0;
        wait_idle(20);
        repeat (5) cyc();
        chk("drop_ack_b_count", 32'(n_ack_b - base), 32'd1);

        // 256 A operations wrap the 8-bit counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            req_a = 1'b1;
            push(1'b0, 1'b0, 1'b0);
            cyc();
            req_a = 1'b0;
            wait_idle(20);
        end
        chk("ops_a_wrap", 32'(ops_a), 32'd0);

        // Reset in the middle of SETUP: no load afterwards, counter untouched
        do_reset();
        base = n_load_a;
        req_a = 1'b1;
        push(1'b0, 1'b0, 1'b0);
        cyc();
        req_a = 1'b0;
        cyc();
        chk("rst_test_in_setup", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        q.delete();
        #1;
        chk("rst_async_out", {7'd0, alu_s, opnd_sel, zero_sel, load_a, load_b, ack_a, ack_b, busy, ops_a, ops_b}, 32'd0);
        cyc();
        rst = 1'b1;
        repeat (8) cyc();
        chk("rst_no_load_a", 32'(n_load_a - base), 32'd0);
        chk("rst_ops_a", 32'(ops_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
